// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-BR datapath: operation codes, datapath width
// and multiplier iteration count. Imported by the arithmetic stage files.
package sap_pkg;

    localparam int WIDTH     = 8;
    localparam int MUL_ITERS = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/ula_multiplier.sv
// Unsigned 8x8 shift-add multiplier, one partial product per clock.
// Ports: clk_i, rst_i (sync, high), start_i, a_i, b_i -> prod_o (16b), busy_o.
module ula_multiplier
    import sap_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic               busy_o
);

    localparam logic [2:0] LAST_CNT = 3'(MUL_ITERS - 1);

    mul_state_e         state_q, state_d;
    logic [WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2:0]         cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // Operands are copied so later B/ACC loads cannot disturb the run.
                if (start_i) begin
                    state_d = ST_RUN;
                    ma_d    = a_i;
                    mb_d    = b_i;
                    prod_d  = '0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (mb_q[0]) begin
                    prod_d = prod_q + ({{WIDTH{1'b0}}, ma_q} << cnt_q);
                end
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign prod_o = prod_q;
    assign busy_o = (state_q == ST_RUN);

endmodule

// File: rtl/ula_b_stage.sv
// Arithmetic stage: B register, op mux against the accumulator, C/Z/N flags,
// tri-state bus driver, and a multi-cycle multiplier.
// Ports: CLOCK, RESET (sync, high), BUS_IN, _EN_B_IN, ACC_IN_ULA, OP, _START,
// _EN_FLAGS, _EN_ULA_OUT -> ULA_OUT (tri-state), B_OUT, FLAG_C/Z/N, BUSY.
module ula_b_stage #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] BUS_IN,
    input  logic             _EN_B_IN,
    input  logic [WIDTH-1:0] ACC_IN_ULA,
    input  logic [2:0]       OP,
    input  logic             _START,
    input  logic             _EN_FLAGS,
    input  logic             _EN_ULA_OUT,
    output logic [WIDTH-1:0] ULA_OUT,
    output logic [WIDTH-1:0] B_OUT,
    output logic             FLAG_C,
    output logic             FLAG_Z,
    output logic             FLAG_N,
    output logic             BUSY
);

    import sap_pkg::*;

    logic [WIDTH-1:0]   b_q, b_d;
    logic               c_q, z_q, n_q;
    logic [WIDTH-1:0]   res;
    logic               res_c;
    logic [2*WIDTH-1:0] prod;
    logic               mul_start;
    logic               busy;

    assign b_d = _EN_B_IN ? b_q : BUS_IN;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            b_q <= '0;
        end else begin
            b_q <= b_d;
        end
    end

    assign mul_start = ~_START & (OP == OP_MUL);

    ula_multiplier u_mul (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .start_i (mul_start),
        .a_i     (ACC_IN_ULA),
        .b_i     (b_q),
        .prod_o  (prod),
        .busy_o  (busy)
    );

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        unique case (OP)
            OP_ADD: {res_c, res} = {1'b0, ACC_IN_ULA} + {1'b0, b_q};
            // Carry out of A + ~B + 1 is set when no borrow occurred.
            OP_SUB: {res_c, res} = {1'b0, ACC_IN_ULA} + {1'b0, ~b_q} + 9'd1;
            OP_AND: res = ACC_IN_ULA & b_q;
            OP_OR:  res = ACC_IN_ULA | b_q;
            OP_XOR: res = ACC_IN_ULA ^ b_q;
            OP_NOT: res = ~ACC_IN_ULA;
            OP_SHL: begin
                res   = {ACC_IN_ULA[WIDTH-2:0], 1'b0};
                res_c = ACC_IN_ULA[WIDTH-1];
            end
            OP_MUL: begin
                res   = prod[WIDTH-1:0];
                res_c = |prod[2*WIDTH-1:WIDTH];
            end
            default: res = '0;
        endcase
    end

    // Flags only latch settled results, so loads during a multiply are dropped.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (!_EN_FLAGS && !busy) begin
            c_q <= res_c;
            z_q <= (res == '0);
            n_q <= res[WIDTH-1];
        end
    end

    assign ULA_OUT = _EN_ULA_OUT ? {WIDTH{1'bz}} : res;
    assign B_OUT   = b_q;
    assign FLAG_C  = c_q;
    assign FLAG_Z  = z_q;
    assign FLAG_N  = n_q;
    assign BUSY    = busy;

endmodule

// File: tb/tb_ula_b_stage.sv
// Self-checking bench for ula_b_stage: directed cases plus randomized ops
// and multiplies, compared against a plain-arithmetic reference model.
module tb_ula_b_stage;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BUS_IN = 8'h00;
    logic       _EN_B_IN = 1'b1;
    logic [7:0] ACC_IN_ULA = 8'h00;
    logic [2:0] OP = 3'd0;
    logic       _START = 1'b1;
    logic       _EN_FLAGS = 1'b1;
    logic       _EN_ULA_OUT = 1'b1;
    wire  [7:0] ULA_OUT;
    logic [7:0] B_OUT;
    logic       FLAG_C, FLAG_Z, FLAG_N, BUSY;

    int vectors = 0;
    int errors  = 0;

    logic [7:0]  m_b;
    logic        m_c, m_z, m_n;
    logic [15:0] m_prod;

    ula_b_stage #(.WIDTH(8)) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .BUS_IN      (BUS_IN),
        ._EN_B_IN    (_EN_B_IN),
        .ACC_IN_ULA  (ACC_IN_ULA),
        .OP          (OP),
        ._START      (_START),
        ._EN_FLAGS   (_EN_FLAGS),
        ._EN_ULA_OUT (_EN_ULA_OUT),
        .ULA_OUT     (ULA_OUT),
        .B_OUT       (B_OUT),
        .FLAG_C      (FLAG_C),
        .FLAG_Z      (FLAG_Z),
        .FLAG_N      (FLAG_N),
        .BUSY        (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    // Returns {carry, result} from the arithmetic meaning of each op.
    function automatic logic [8:0] ref_op(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [15:0] p);
        int s;
        logic [7:0] r;
        logic c;
        r = 8'h00;
        c = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
            3'd1: begin r = 8'(int'(a) - int'(b)); c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 8'(255 - int'(a));
            3'd6: begin r = 8'((int'(a) * 2) % 256); c = (a >= 8'd128); end
            default: begin r = p[7:0]; c = (p > 16'd255); end
        endcase
        return {c, r};
    endfunction

    // Stimulus helpers: each starts and ends just after a falling edge.
    task automatic load_b(input logic [7:0] v);
        BUS_IN = v;
        _EN_B_IN = 1'b0;
        @(negedge CLOCK);
        _EN_B_IN = 1'b1;
        m_b = v;
    endtask

    task automatic load_flags();
        logic [8:0] e;
        e = ref_op(OP, ACC_IN_ULA, m_b, m_prod);
        _EN_FLAGS = 1'b0;
        @(negedge CLOCK);
        _EN_FLAGS = 1'b1;
        m_c = e[8];
        m_z = (e[7:0] == 8'h00);
        m_n = e[7];
    endtask

    task automatic pulse_start(input logic [7:0] a);
        ACC_IN_ULA = a;
        OP = 3'd7;
        _START = 1'b0;
        @(negedge CLOCK);
        _START = 1'b1;
        m_prod = 16'(int'(a) * int'(m_b));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin
            n++;
            @(negedge CLOCK);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        ACC_IN_ULA = 8'h55;
        OP = 3'd0;
        _EN_ULA_OUT = 1'b1;
        @(negedge CLOCK);
        m_b = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_prod = 16'h0;
        vectors++;
        if (B_OUT !== 8'h00) begin
            errors++; $display("FAIL reset_b: got %h need 00", B_OUT);
        end
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N, BUSY} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got CZNB=%b need 0000",
                     {FLAG_C, FLAG_Z, FLAG_N, BUSY});
        end
        vectors++;
        if (ULA_OUT === 8'h55) begin
            errors++; $display("FAIL reset_bus_released: got %h need ZZ", ULA_OUT);
        end
        RESET = 1'b0;
        _EN_ULA_OUT = 1'b0;
        #1;
        vectors++;
        if (ULA_OUT !== 8'h55) begin
            errors++; $display("FAIL reset_bus_drive: got %h need 55", ULA_OUT);
        end
        @(negedge CLOCK);
    endtask

    task automatic test_add();
        load_b(8'h01);
        ACC_IN_ULA = 8'h7F;
        OP = 3'd0;
        #1;
        vectors++;
        if (ULA_OUT !== 8'h80) begin
            errors++; $display("FAIL add_result: got %h need 80", ULA_OUT);
        end
        vectors++;
        if (B_OUT !== 8'h01) begin
            errors++; $display("FAIL add_b_out: got %h need 01", B_OUT);
        end
        load_flags();
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== 3'b001) begin
            errors++;
            $display("FAIL add_flags: got CZN=%b need 001", {FLAG_C, FLAG_Z, FLAG_N});
        end
    endtask

    task automatic test_sub();
        load_b(8'h05);
        ACC_IN_ULA = 8'h05;
        OP = 3'd1;
        #1;
        vectors++;
        if (ULA_OUT !== 8'h00) begin
            errors++; $display("FAIL sub_eq_result: got %h need 00", ULA_OUT);
        end
        load_flags();
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== 3'b110) begin
            errors++;
            $display("FAIL sub_eq_flags: got CZN=%b need 110", {FLAG_C, FLAG_Z, FLAG_N});
        end
        ACC_IN_ULA = 8'h03;
        #1;
        vectors++;
        if (ULA_OUT !== 8'hFE) begin
            errors++; $display("FAIL sub_borrow_result: got %h need FE", ULA_OUT);
        end
        load_flags();
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== 3'b001) begin
            errors++;
            $display("FAIL sub_borrow_flags: got CZN=%b need 001", {FLAG_C, FLAG_Z, FLAG_N});
        end
    endtask

    task automatic test_random_ops();
        logic [8:0] e;
        for (int i = 0; i < 24; i++) begin
            load_b(8'($urandom));
            ACC_IN_ULA = 8'($urandom);
            OP = 3'($urandom_range(0, 6));
            #1;
            e = ref_op(OP, ACC_IN_ULA, m_b, m_prod);
            vectors++;
            if (ULA_OUT !== e[7:0]) begin
                errors++;
                $display("FAIL rand_op%0d: A=%h B=%h got %h need %h",
                         OP, ACC_IN_ULA, m_b, ULA_OUT, e[7:0]);
            end
            load_flags();
            vectors++;
            if ({FLAG_C, FLAG_Z, FLAG_N} !== {m_c, m_z, m_n}) begin
                errors++;
                $display("FAIL rand_flags_op%0d: got CZN=%b need %b",
                         OP, {FLAG_C, FLAG_Z, FLAG_N}, {m_c, m_z, m_n});
            end
        end
    endtask

    task automatic test_mul();
        int n;
        load_b(8'h11);
        pulse_start(8'h10);
        n = 0;
        while (BUSY === 1'b1 && n < 20) begin
            n++;
            if (n == 3) begin
                BUS_IN = 8'hFF; _EN_B_IN = 1'b0; ACC_IN_ULA = 8'hAB;
            end
            if (n == 4) begin
                _EN_B_IN = 1'b1; m_b = 8'hFF;
            end
            @(negedge CLOCK);
        end
        vectors++;
        if (n != 8) begin
            errors++; $display("FAIL mul_busy_cycles: got %0d need 8", n);
        end
        vectors++;
        if (ULA_OUT !== 8'h10) begin
            errors++; $display("FAIL mul_result: got %h need 10", ULA_OUT);
        end
        load_flags();
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== 3'b100) begin
            errors++;
            $display("FAIL mul_flags: got CZN=%b need 100", {FLAG_C, FLAG_Z, FLAG_N});
        end
    endtask

    task automatic test_mul_reset();
        int n;
        load_b(8'h9C);
        pulse_start(8'hE3);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        m_b = 8'h00; m_prod = 16'h0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
        vectors++;
        if (BUSY !== 1'b0 || ULA_OUT !== 8'h00 || B_OUT !== 8'h00) begin
            errors++;
            $display("FAIL mulrst_clear: got BUSY=%b OUT=%h B=%h need 0 00 00",
                     BUSY, ULA_OUT, B_OUT);
        end
        load_b(8'h0D);
        pulse_start(8'h0F);
        wait_idle(n);
        vectors++;
        if (n != 8 || ULA_OUT !== m_prod[7:0]) begin
            errors++;
            $display("FAIL mulrst_restart: got %0d cycles %h need 8 cycles %h",
                     n, ULA_OUT, m_prod[7:0]);
        end
    endtask

    task automatic test_flags_busy();
        int n;
        load_b(8'h00);
        ACC_IN_ULA = 8'h00;
        OP = 3'd0;
        load_flags();
        load_b(8'hFF);
        pulse_start(8'hFF);
        _EN_FLAGS = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        _EN_FLAGS = 1'b1;
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== {m_c, m_z, m_n}) begin
            errors++;
            $display("FAIL flags_held_busy: got CZN=%b need %b",
                     {FLAG_C, FLAG_Z, FLAG_N}, {m_c, m_z, m_n});
        end
        wait_idle(n);
        vectors++;
        if (ULA_OUT !== 8'h01) begin
            errors++; $display("FAIL mul_ff: got %h need 01", ULA_OUT);
        end
        load_flags();
        vectors++;
        if ({FLAG_C, FLAG_Z, FLAG_N} !== {m_c, m_z, m_n}) begin
            errors++;
            $display("FAIL mul_ff_flags: got CZN=%b need %b",
                     {FLAG_C, FLAG_Z, FLAG_N}, {m_c, m_z, m_n});
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] a2, b2;
        load_b(8'($urandom));
        ACC_IN_ULA = 8'($urandom);
        OP = 3'd7;
        m_prod = 16'(int'(ACC_IN_ULA) * int'(m_b));
        _START = 1'b0;
        @(negedge CLOCK);
        for (int i = 0; i < 4; i++) begin
            wait_idle(n);
            vectors++;
            if (n != 8 || ULA_OUT !== m_prod[7:0]) begin
                errors++;
                $display("FAIL b2b_run%0d: got %0d cycles %h need 8 cycles %h",
                         i, n, ULA_OUT, m_prod[7:0]);
            end
            // B load and restart share an edge: the new run uses the old B.
            a2 = 8'($urandom);
            b2 = 8'($urandom);
            ACC_IN_ULA = a2;
            BUS_IN = b2;
            _EN_B_IN = 1'b0;
            m_prod = 16'(int'(a2) * int'(m_b));
            m_b = b2;
            @(negedge CLOCK);
            _EN_B_IN = 1'b1;
            vectors++;
            if (BUSY !== 1'b1) begin
                errors++; $display("FAIL b2b_restart%0d: got BUSY=%b need 1", i, BUSY);
            end
        end
        _START = 1'b1;
        wait_idle(n);
        load_flags();
        vectors++;
        if (ULA_OUT !== m_prod[7:0] || FLAG_C !== m_c) begin
            errors++;
            $display("FAIL b2b_final: got %h C=%b need %h C=%b",
                     ULA_OUT, FLAG_C, m_prod[7:0], m_c);
        end
    endtask

    initial begin
        @(negedge CLOCK);
        test_reset();
        test_add();
        test_sub();
        test_random_ops();
        test_mul();
        test_mul_reset();
        test_flags_busy();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
